// File: rtl/clock_ratio_detector.sv
// clock_ratio_detector: oversamples a slower clock (clk_div) in the clk_in domain.
// For each clk_div period it reports the period and the high time in clk_in cycles,
// and it declares lock once consecutive measurements agree exactly.
module clock_ratio_detector #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clk_div,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam int unsigned          MATCH_W  = 8;
  // per_q at this value with no rise means the next increment would hit all-ones
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = ~CNT_WIDTH'(1);
  localparam logic [MATCH_W-1:0]   LOCK_TGT = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_WIDTH-1:0]   per_q;
  logic [CNT_WIDTH-1:0]   hi_q;
  logic [CNT_WIDTH-1:0]   period_q;
  logic [CNT_WIDTH-1:0]   high_q;
  logic [MATCH_W-1:0]     match_q;
  logic [MATCH_W-1:0]     match_d;
  logic                   first_q;
  logic                   meas_valid_q;
  logic                   locked_q;
  logic                   timeout_q;

  logic                   s_c;
  logic                   rise_c;
  logic                   sat_c;

  // Synchronizer chain for the asynchronous clk_div, plus one delay flop for edge detect
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_c    = sync_q[SYNC_STAGES-1];
  assign rise_c = s_c & ~s_d_q;
  // A rise in the same cycle takes precedence over saturation
  assign sat_c  = (per_q == CNT_SAT) & ~rise_c;

  // Match counter for the measurement completing now; the first one after SEEK never matches
  always_comb begin
    match_d = '0;
    if (!first_q && (per_q == period_q) && (hi_q == high_q)) begin
      if (match_q == LOCK_TGT) begin
        match_d = match_q;
      end else begin
        match_d = match_q + MATCH_W'(1);
      end
    end
  end

  // Measurement FSM with registered outputs; enable low overrides everything
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      per_q        <= '0;
      hi_q         <= '0;
      period_q     <= '0;
      high_q       <= '0;
      match_q      <= '0;
      first_q      <= 1'b1;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (!enable) begin
        state_q  <= ST_IDLE;
        per_q    <= '0;
        hi_q     <= '0;
        match_q  <= '0;
        first_q  <= 1'b1;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SEEK;
            per_q   <= '0;
            hi_q    <= '0;
          end
          ST_SEEK: begin
            if (rise_c) begin
              state_q <= ST_MEASURE;
              per_q   <= CNT_WIDTH'(1);
              hi_q    <= CNT_WIDTH'(1);
              match_q <= '0;
              first_q <= 1'b1;
            end else if (sat_c) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
              per_q     <= '0;
            end else begin
              per_q <= per_q + CNT_WIDTH'(1);
            end
          end
          ST_MEASURE: begin
            if (rise_c) begin
              period_q     <= per_q;
              high_q       <= hi_q;
              meas_valid_q <= 1'b1;
              per_q        <= CNT_WIDTH'(1);
              hi_q         <= CNT_WIDTH'(1);
              match_q      <= match_d;
              locked_q     <= (match_d == LOCK_TGT);
              first_q      <= 1'b0;
            end else if (sat_c) begin
              state_q   <= ST_SEEK;
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
              per_q     <= '0;
              hi_q      <= '0;
            end else begin
              per_q <= per_q + CNT_WIDTH'(1);
              if (s_c) begin
                hi_q <= hi_q + CNT_WIDTH'(1);
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Directed bench for clock_ratio_detector: a default-parameter instance for
// measurement/lock/reset/enable behaviour and an 8-bit instance for saturation.
module tb_clock_ratio_detector;

  logic        clk_in;
  logic        reset;
  logic        enable;
  logic        clk_div;
  logic [15:0] period_out;
  logic [15:0] high_out;
  logic        meas_valid;
  logic        locked;
  logic        timeout;

  logic        en8;
  logic        clk_div8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        mv8;
  logic        locked8;
  logic        to8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // clk_div pattern generator state (high/low lengths in clk_in cycles)
  bit gen_on    = 1'b0;
  int gen_hi_nx = 1;
  int gen_lo_nx = 1;
  int gen_hi;
  int gen_lo;
  int gen_ph;
  int last_cap;

  clock_ratio_detector u_dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .clk_div    (clk_div),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  clock_ratio_detector #(.CNT_WIDTH(8)) u_dut8 (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (en8),
    .clk_div    (clk_div8),
    .period_out (period8),
    .high_out   (high8),
    .meas_valid (mv8),
    .locked     (locked8),
    .timeout    (to8)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Drives clk_div on falling edges; last_cap is the rising clk_in edge at which
  // synchronizer stage 1 captures the newest clk_div rising edge.
  initial begin
    clk_div  = 1'b0;
    gen_ph   = 0;
    gen_hi   = 1;
    gen_lo   = 1;
    last_cap = 0;
    forever begin
      @(negedge clk_in);
      if (!gen_on) begin
        clk_div = 1'b0;
        gen_ph  = 0;
      end else begin
        if (gen_ph == 0) begin
          gen_hi   = gen_hi_nx;
          gen_lo   = gen_lo_nx;
          last_cap = cyc + 1;
        end
        clk_div = (gen_ph < gen_hi);
        gen_ph  = (gen_ph + 1 >= gen_hi + gen_lo) ? 0 : gen_ph + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic wait_mv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Collect n measurements; locked is expected from the lock_from-th one onwards
  task automatic run_meas(input string tag, input int n, input int exp_per, input int exp_hi,
                          input int lock_from, input int exp_gap, input bit chk_lat);
    int prev;
    bit ok;
    prev = 0;
    for (int i = 1; i <= n; i++) begin
      wait_mv(40, ok);
      if (!ok) begin
        check_eq({tag, "_mv_seen"}, int'(meas_valid), 1);
        return;
      end
      check_eq({tag, "_period"}, int'(period_out), exp_per);
      check_eq({tag, "_high"}, int'(high_out), exp_hi);
      check_eq({tag, "_locked"}, int'(locked), (i >= lock_from) ? 1 : 0);
      if (chk_lat) check_eq({tag, "_latency"}, cyc - last_cap, 2);
      if (exp_gap > 0 && i > 1) check_eq({tag, "_gap"}, cyc - prev, exp_gap);
      prev = cyc;
    end
  endtask

  // Watch the 8-bit instance: timeouts 255 cycles apart, never a measurement or lock
  task automatic to_run(input string tag, input int cycles);
    int last;
    int n;
    int mvs;
    last = 0;
    n    = 0;
    mvs  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (mv8) mvs++;
      if (to8) begin
        n++;
        check_eq({tag, "_locked"}, int'(locked8), 0);
        if (n > 1) check_eq({tag, "_gap"}, i - last, 255);
        last = i;
      end
    end
    check_eq({tag, "_mv_count"}, mvs, 0);
    check_eq({tag, "_to_count_ge3"}, (n >= 3) ? 1 : 0, 1);
    check_eq({tag, "_period_hold"}, int'(period8), 0);
  endtask

  initial begin
    bit found;
    reset    = 1'b1;
    enable   = 1'b0;
    en8      = 1'b0;
    clk_div8 = 1'b0;

    repeat (3) @(negedge clk_in);
    check_eq("rst_period", int'(period_out), 0);
    check_eq("rst_high", int'(high_out), 0);
    check_eq("rst_mv", int'(meas_valid), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    check_eq("rst8_timeout", int'(to8), 0);
    reset = 1'b0;

    // Divide-by-2
    gen_hi_nx = 1;
    gen_lo_nx = 1;
    gen_on    = 1'b1;
    repeat (4) @(negedge clk_in);
    enable = 1'b1;
    run_meas("div2", 6, 2, 1, 5, 2, 1'b0);

    // Disable: IDLE clears lock, outputs hold
    enable = 1'b0;
    gen_on = 1'b0;
    repeat (4) @(negedge clk_in);
    check_eq("idle_locked", int'(locked), 0);
    check_eq("idle_period_hold", int'(period_out), 2);
    check_eq("idle_high_hold", int'(high_out), 1);

    // Divide-by-8 started cleanly from SEEK, with latency checks
    gen_hi_nx = 4;
    gen_lo_nx = 4;
    enable    = 1'b1;
    repeat (4) @(negedge clk_in);
    gen_on = 1'b1;
    run_meas("div8", 5, 8, 4, 5, 8, 1'b1);

    // Switch to divide-by-4 at the next period boundary
    gen_hi_nx = 2;
    gen_lo_nx = 2;
    run_meas("div8_tail", 1, 8, 4, 1, 0, 1'b1);
    run_meas("div4", 5, 4, 2, 5, 4, 1'b1);

    // Asynchronous reset mid-period while locked
    @(negedge clk_in);
    check_eq("pre_rst_locked", int'(locked), 1);
    reset = 1'b1;
    #1;
    check_eq("arst_period", int'(period_out), 0);
    check_eq("arst_high", int'(high_out), 0);
    check_eq("arst_mv", int'(meas_valid), 0);
    check_eq("arst_locked", int'(locked), 0);
    check_eq("arst_timeout", int'(timeout), 0);
    repeat (3) @(negedge clk_in);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      #1;
      if (clk_div == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst_release_low_found", found ? 1 : 0, 1);
    reset = 1'b0;
    run_meas("rst_resume", 6, 4, 2, 5, 4, 1'b1);

    // Drop enable in the cycle a rise is being detected
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (cyc == last_cap + 1) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("en_drop_align", found ? 1 : 0, 1);
    check_eq("en_drop_pre_locked", int'(locked), 1);
    enable = 1'b0;
    @(negedge clk_in);
    check_eq("en_drop_mv", int'(meas_valid), 0);
    check_eq("en_drop_locked", int'(locked), 0);
    check_eq("en_drop_period", int'(period_out), 4);
    check_eq("en_drop_high", int'(high_out), 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check_eq("en_off_mv", int'(meas_valid), 0);
    end
    enable = 1'b1;
    run_meas("reenable", 5, 4, 2, 5, 4, 1'b1);

    // Saturation on the 8-bit instance: clk_div held low, then held high
    en8 = 1'b1;
    to_run("sat_low", 1000);
    clk_div8 = 1'b1;
    to_run("sat_high", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_ratio_detector.md
# clock_ratio_detector

Measures an incoming divided clock (`clk_div`) by oversampling it in the `clk_in` domain. For each period it reports the period and the high time in `clk_in` cycles. It declares lock once the measurement is stable over consecutive periods. It sits downstream of the clock divider outputs as a self-check and monitoring block, and is also usable on any slower external clock.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the period and high-time counters and outputs.
- `LOCK_COUNT`, default 4: number of consecutive matching measurements required for lock (1 to 255).
- `SYNC_STAGES`, default 2: number of synchronizer flops on `clk_div` (at least 2).

Ports:
- `clk_in`, input, 1: clock. Rising edge active.
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: measurement enable. Low forces IDLE.
- `clk_div`, input, 1: clock under measurement. Asynchronous to `clk_in`.
- `period_out`, output, CNT_WIDTH: last measured period in `clk_in` cycles.
- `high_out`, output, CNT_WIDTH: last measured high time in `clk_in` cycles.
- `meas_valid`, output, 1: one-cycle pulse when `period_out`/`high_out` update.
- `locked`, output, 1: measurement stable.
- `timeout`, output, 1: one-cycle pulse when the counter saturates with no rising edge seen.

## Operation
- Synchronizer: `clk_div` passes through SYNC_STAGES flops to give `s`. A further register gives `s_d`. A rising edge is `rise = s & ~s_d`.
- State IDLE: entered on reset or whenever `enable` = 0 (from any state). Counters are cleared and `locked` = 0. `period_out` and `high_out` hold their values. When `enable` = 1, go to SEEK.
- State SEEK: waits for the first `rise`.
  - `per_cnt` increments every cycle.
  - On `rise`: set `per_cnt` = 1 and `hi_cnt` = 1, clear `match_cnt`, and go to MEASURE. No `meas_valid` is issued.
- State MEASURE:
  - Each cycle without `rise`: `per_cnt` += 1. `hi_cnt` += 1 if `s` = 1.
  - On `rise`:
    - Load `period_out` ← `per_cnt` and `high_out` ← `hi_cnt`, and pulse `meas_valid`.
    - Then set `per_cnt` = 1 and `hi_cnt` = 1.
- Lock logic, evaluated on each `meas_valid`:
  - If this is the first measurement since SEEK, `match_cnt` = 0.
  - Else, if the new `per_cnt` and `hi_cnt` equal the current `period_out` and `high_out`, `match_cnt` += 1, saturating at LOCK_COUNT.
  - Else `match_cnt` = 0 and `locked` drops in the same cycle as `meas_valid`.
  - `locked` = 1 whenever `match_cnt` == LOCK_COUNT.
- Saturation: if `per_cnt` reaches 2^CNT_WIDTH−1 with no `rise`, in SEEK or MEASURE:
  - Pulse `timeout` and clear `locked` and `match_cnt`.
  - Set `per_cnt` = 0 and enter (or stay in) SEEK.
  - `period_out` and `high_out` hold.
- Simultaneous events:
  - `rise` in the same cycle as saturation: `rise` wins and saturation is ignored.
  - `enable` falling in the same cycle as `rise`: IDLE wins, and no `meas_valid` is issued.
- Arithmetic: all counters are unsigned CNT_WIDTH bits. No wrap-around is permitted; counters saturate as described above.
- Minimum measurable period is 2 cycles. Inputs faster than `clk_in`/2 alias, and no detection of this is required.

## Timing
- Reset values: `period_out` = 0, `high_out` = 0, `meas_valid` = 0, `locked` = 0, `timeout` = 0. State is IDLE and all synchronizer flops are 0.
- Reset is asynchronous assert. Assertion mid-measurement discards the measurement in progress with no pulse.
- Latency: if synchronizer stage 1 first captures `clk_div` = 1 at `clk_in` edge k, then `meas_valid`, `period_out` and `high_out` update at edge k+SYNC_STAGES.
- `meas_valid` and `timeout` are exactly one cycle wide.
- `locked` is registered and changes only on the edge that pulses `meas_valid`, on the edge that pulses `timeout`, or on the edge entering IDLE.
- Earliest lock: `locked` rises with the (LOCK_COUNT+1)-th `meas_valid` after SEEK exits.
- Jitter of ±1 cycle in sampled edges counts as a mismatch. There is no tolerance window.

## Test plan
- Divide-by-2 input (1 high, 1 low), enable = 1, default parameters → `meas_valid` every 2 cycles with `period_out` = 2 and `high_out` = 1. `locked` = 1 on the 5th `meas_valid`.
- Divide-by-8 input (4 high, 4 low) → `period_out` = 8 and `high_out` = 4. First `meas_valid` occurs SYNC_STAGES cycles after stage 1 captures the second rising edge.
- Locked on divide-by-8, then switch the input to divide-by-4 → `locked` drops on the first `meas_valid` reporting period 4. It re-locks after 4 further matching periods.
- CNT_WIDTH = 8, `clk_div` held at 0 → `timeout` pulses every 255 cycles, with no `meas_valid` and `locked` = 0. Then hold `clk_div` at 1 → same result.
- Assert `reset` mid-period while locked → all outputs are 0 immediately. After release, the first `rise` issues no `meas_valid`, and measurements then resume correctly.
- Deassert `enable` while locked, on a `rise` cycle → no `meas_valid`, `locked` = 0, and `period_out` holds its last value. Re-enable → the SEEK sequence repeats.
